// File: rtl/sram_req_ctrl_if.sv
// Bundle of the upstream request/response channel and the SRAM macro pins
// that the controller drives. The slave modport is the controller's view.
// The master modport is the environment's view: the upstream client plus the
// macro, which returns dout0.
interface sram_req_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // upstream request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;

  // upstream response channel
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_write;
  logic [DATA_W-1:0] resp_rdata;

  // macro pins (csb0/web0 active-low)
  logic              sram_csb0;
  logic              sram_web0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [DATA_W-1:0] sram_din0;
  logic [DATA_W-1:0] sram_dout0;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready,
    output resp_valid, resp_write, resp_rdata,
    input  resp_ready,
    output sram_csb0, sram_web0, sram_addr0, sram_din0,
    input  sram_dout0
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  req_ready,
    input  resp_valid, resp_write, resp_rdata,
    output resp_ready,
    input  sram_csb0, sram_web0, sram_addr0, sram_din0,
    output sram_dout0
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// Request/response controller for a single-port SRAM macro that is clocked on
// the falling edge. It issues at most one macro operation per cycle. Partial
// writes are performed as a read followed by a merged write. Each request gets
// exactly one registered response, and responses are returned in order.
module sram_req_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,   // synchronous, active-low
  sram_req_ctrl_if.slave    bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_write_q, resp_write_d;
  logic              op_write_q, op_write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] merge_data;
  logic              req_ready;
  logic              accept;

  // A new request is taken only when nothing is in flight, or when the pending
  // response leaves in this same cycle.
  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.resp_ready);
  assign accept    = bus.req_valid & req_ready;

  // Per-byte merge of the held write data over the word just read from the macro
  generate
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_merge
      assign merge_data[gi*8 +: 8] = wmask_q[gi] ? wdata_q[gi*8 +: 8]
                                                 : bus.sram_dout0[gi*8 +: 8];
    end
  endgenerate

  // Next-state and registered-output logic; the macro returns to idle (csb0=1) by default
  always_comb begin
    state_d      = state_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    addr_d       = addr_q;
    din_d        = din_q;
    rdata_d      = rdata_q;
    resp_write_d = resp_write_q;
    op_write_d   = op_write_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        resp_write_d = op_write_q;
        rdata_d      = op_write_q ? '0 : bus.sram_dout0;
      end
      ST_RMW_RD: begin
        state_d = ST_RMW_WR;
        csb_d   = 1'b0;
        web_d   = 1'b0;
        din_d   = merge_data;
      end
      ST_RMW_WR: begin
        state_d      = ST_RESP;
        resp_write_d = 1'b1;
        rdata_d      = '0;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // accept only happens in IDLE or RESP, so it overrides the hold/drain above
    if (accept) begin
      op_write_d = bus.req_write;
      wdata_d    = bus.req_wdata;
      wmask_d    = bus.req_wmask;
      if (!bus.req_write) begin
        state_d = ST_ACCESS;
        csb_d   = 1'b0;
        web_d   = 1'b1;
        addr_d  = bus.req_addr;
      end else if (&bus.req_wmask) begin
        state_d = ST_ACCESS;
        csb_d   = 1'b0;
        web_d   = 1'b0;
        addr_d  = bus.req_addr;
        din_d   = bus.req_wdata;
      end else if (bus.req_wmask == '0) begin
        // nothing to write: acknowledge immediately without touching the macro
        state_d      = ST_RESP;
        resp_write_d = 1'b1;
        rdata_d      = '0;
      end else begin
        state_d = ST_RMW_RD;
        csb_d   = 1'b0;
        web_d   = 1'b1;
        addr_d  = bus.req_addr;
      end
    end
  end

  // State and output registers; reset drops any pending response and idles the macro
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      addr_q       <= '0;
      din_q        <= '0;
      rdata_q      <= '0;
      resp_write_q <= 1'b0;
      op_write_q   <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rdata_q      <= rdata_d;
      resp_write_q <= resp_write_d;
      op_write_q   <= op_write_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_write = resp_write_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.sram_csb0  = csb_q;
  assign bus.sram_web0  = web_q;
  assign bus.sram_addr0 = addr_q;
  assign bus.sram_din0  = din_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Testbench for sram_req_ctrl: a falling-edge SRAM macro model, a reference
// memory and a queue of expected responses.
module tb_sram_req_ctrl;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sram_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // macro model: operates on the falling edge when selected
  logic [31:0] macro_mem [0:127];
  logic [31:0] dout_r;
  always @(negedge clock) begin
    if (bus.sram_csb0 == 1'b0) begin
      if (bus.sram_web0 == 1'b0) macro_mem[bus.sram_addr0] <= bus.sram_din0;
      else                       dout_r <= macro_mem[bus.sram_addr0];
    end
  end
  assign bus.sram_dout0 = dout_r;

  int csb_low_cnt = 0;
  always @(negedge clock) if (bus.sram_csb0 == 1'b0) csb_low_cnt++;

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [0:127];
  logic [32:0] exp_q [$];   // {resp_write, rdata}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_push(input logic wr, input logic [6:0] a,
                             input logic [31:0] d, input logic [3:0] m);
    if (!wr) begin
      exp_q.push_back({1'b0, ref_mem[a]});
    end else begin
      for (int b = 0; b < 4; b++)
        if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      exp_q.push_back({1'b1, 32'h0});
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [32:0] e;
    check({tag, "_queue_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_write"}, 64'(bus.resp_write), 64'(e[32]));
      check({tag, "_rdata"}, 64'(bus.resp_rdata), 64'(e[31:0]));
    end
  endtask

  // Present the request already driven on the bus until it is accepted (bounded).
  task automatic wait_accept();
    bit acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clock);
      if (bus.req_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    check("req_accept", 64'(acc), 64'd1);
  endtask

  // Wait for the response of an accepted request; lat counts edges after accept.
  task automatic wait_resp(input logic wr, input logic [6:0] a, input logic [3:0] m,
                           input logic [31:0] merged, input int exp_lat);
    bit got = 1'b0;
    int lat = 0;
    bit partial;
    partial = wr && (m != 4'h0) && (m != 4'hF);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        if (partial && lat == 0) begin
          check("rmw_rd_csb0", 64'(bus.sram_csb0), 64'd0);
          check("rmw_rd_web0", 64'(bus.sram_web0), 64'd1);
          check("rmw_rd_addr0", 64'(bus.sram_addr0), 64'(a));
        end
        if (partial && lat == 1) begin
          check("rmw_wr_csb0", 64'(bus.sram_csb0), 64'd0);
          check("rmw_wr_web0", 64'(bus.sram_web0), 64'd0);
          check("rmw_wr_din0", 64'(bus.sram_din0), 64'(merged));
        end
        @(posedge clock); #1;
        lat++;
      end
    end
    check("resp_seen", 64'(got), 64'd1);
    if (got) begin
      check("latency", 64'(lat), 64'(exp_lat));
      pop_cmp("resp");
      @(posedge clock); #1;
    end
  endtask

  task automatic send(input logic wr, input logic [6:0] a, input logic [31:0] d,
                      input logic [3:0] m, input int exp_lat);
    logic [31:0] merged;
    expect_push(wr, a, d, m);
    merged = ref_mem[a];
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    wait_accept();
    bus.req_valid = 1'b0;
    wait_resp(wr, a, m, merged, exp_lat);
    $display("[TB] %s addr=%0d wdata=%h mask=%h exp_lat=%0d",
             wr ? "WR" : "RD", a, d, m, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int rv_seen;
    logic       rwr;
    logic [6:0] ra;
    logic [3:0] rm;
    int         sel;
    int         rlat;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wmask  = '0;
    bus.resp_ready = 1'b1;
    reset          = 1'b0;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_csb0", 64'(bus.sram_csb0), 64'd1);
    check("rst_web0", 64'(bus.sram_web0), 64'd1);
    check("rst_addr0", 64'(bus.sram_addr0), 64'd0);
    check("rst_din0", 64'(bus.sram_din0), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_write", 64'(bus.resp_write), 64'd0);
    check("rst_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    $display("[TB] reset released");

    // full write then read
    send(1'b1, 7'd5, 32'hDEADBEEF, 4'hF, 1);
    send(1'b0, 7'd5, 32'h0, 4'h0, 1);

    // partial write (read-modify-write) then readback
    send(1'b1, 7'd5, 32'h0000AB00, 4'b0010, 2);
    send(1'b0, 7'd5, 32'h0, 4'h0, 1);

    // backpressure on a read of the top address
    send(1'b1, 7'd127, 32'h12345678, 4'hF, 1);
    bus.resp_ready = 1'b0;
    expect_push(1'b0, 7'd127, 32'h0, 4'h0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 7'd127;
    bus.req_wmask = 4'h3;   // ignored for reads
    wait_accept();
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_rdata_stable", 64'(bus.resp_rdata), 64'h12345678);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
      check("bp_csb0", 64'(bus.sram_csb0), 64'd1);
      @(posedge clock); #1;
    end
    expect_push(1'b0, 7'd5, 32'h0, 4'h0);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 7'd5;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("bp_release_req_ready", 64'(bus.req_ready), 64'd1);
    pop_cmp("bp_resp");
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    wait_resp(1'b0, 7'd5, 4'h0, 32'h0, 1);
    $display("[TB] RD addr=127 under backpressure, RD addr=5 accepted on handshake");

    // zero-mask write: no macro access, immediate response
    send(1'b1, 7'd3, 32'hA5A55A5A, 4'hF, 1);
    cnt0 = csb_low_cnt;
    send(1'b1, 7'd3, 32'hFFFFFFFF, 4'h0, 0);
    check("zero_mask_csb_idle", 64'(csb_low_cnt - cnt0), 64'd0);
    send(1'b0, 7'd3, 32'h0, 4'h0, 1);

    // reset during RMW_RD drops the request and leaves memory intact
    send(1'b1, 7'd9, 32'hCAFEF00D, 4'hF, 1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 7'd9;
    bus.req_wdata = 32'h000000FF;
    bus.req_wmask = 4'b0001;
    wait_accept();
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("rst_rmw_in_rd", 64'(bus.sram_csb0), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_rmw_csb0", 64'(bus.sram_csb0), 64'd1);
    check("rst_rmw_web0", 64'(bus.sram_web0), 64'd1);
    check("rst_rmw_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.resp_valid) rv_seen++;
      @(posedge clock); #1;
    end
    check("rst_rmw_no_resp", 64'(rv_seen), 64'd0);
    $display("[TB] reset during RMW_RD at addr=9");
    send(1'b0, 7'd9, 32'h0, 4'h0, 1);

    // mixed traffic over a small address window
    for (int i = 0; i < 8; i++)
      send(1'b1, 7'(16 + i), $urandom, 4'hF, 1);
    for (int i = 0; i < 16; i++) begin
      ra  = 7'(16 + $urandom_range(0, 7));
      rwr = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 2));
      rm  = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
      rlat = !rwr ? 1 : (rm == 4'h0) ? 0 : (rm == 4'hF) ? 1 : 2;
      send(rwr, ra, $urandom, rm, rlat);
    end
    for (int i = 0; i < 8; i++)
      send(1'b0, 7'(16 + i), 32'h0, 4'h0, 1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
